// File: rtl/decoder_2to4.sv
// One-hot 2:4 decoder with enable, valid qualifier and selectable output polarity.
// Latency 1 cycle (REGISTERED=1) or 0 (REGISTERED=0); no backpressure, one decode every cycle.
module decoder_2to4 #(
    parameter bit REGISTERED     = 1'b1,
    parameter bit ACTIVE_LOW_OUT = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic in1,
    input  logic in2,
    output logic out1,
    output logic out2,
    output logic out3,
    output logic out4,
    output logic valid
);

    localparam logic [3:0] INACTIVE = {4{ACTIVE_LOW_OUT}};

    // Bit 3 is out1 ... bit 0 is out4; polarity is applied after the decode.
    logic [3:0] w_dec;
    logic [3:0] w_pol;
    logic [3:0] w_out;
    logic       w_vld;

    assign w_dec = {en & ~in1 & ~in2,
                    en & ~in1 &  in2,
                    en &  in1 & ~in2,
                    en &  in1 &  in2};
    assign w_pol = w_dec ^ INACTIVE;

    generate
        if (REGISTERED) begin : g_reg
            logic [3:0] r_out;
            logic       r_vld;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_out <= INACTIVE;
                    r_vld <= 1'b0;
                end else begin
                    r_out <= w_pol;
                    r_vld <= en;
                end
            end

            assign w_out = r_out;
            assign w_vld = r_vld;
        end else begin : g_comb
            // Clock has no role in this mode.
            logic w_clk_unused;
            assign w_clk_unused = clk;

            assign w_out = rst_n ? w_pol : INACTIVE;
            assign w_vld = rst_n & en;
        end
    endgenerate

    assign {out1, out2, out3, out4} = w_out;
    assign valid = w_vld;

endmodule

// File: tb/tb_decoder_2to4.sv
// Scoreboarded bench for decoder_2to4: registered, polarity-inverted and combinational instances.
module tb_decoder_2to4;

    logic clk     = 1'b0;
    logic clk_run = 1'b1;
    logic rst_n   = 1'b1;
    logic en      = 1'b0;
    logic in1     = 1'b0;
    logic in2     = 1'b0;

    logic r_o1, r_o2, r_o3, r_o4, r_v;
    logic p_o1, p_o2, p_o3, p_o4, p_v;
    logic c_o1, c_o2, c_o3, c_o4, c_v;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic       chk_rp;
        logic [4:0] exp_r;
        logic [4:0] exp_p;
        logic [4:0] exp_c;
    } exp_t;

    exp_t q_sync[$];
    exp_t q_async[$];
    event probe_ev;

    decoder_2to4 #(.REGISTERED(1'b1), .ACTIVE_LOW_OUT(1'b0)) u_reg (
        .clk(clk), .rst_n(rst_n), .en(en), .in1(in1), .in2(in2),
        .out1(r_o1), .out2(r_o2), .out3(r_o3), .out4(r_o4), .valid(r_v)
    );

    decoder_2to4 #(.REGISTERED(1'b1), .ACTIVE_LOW_OUT(1'b1)) u_pol (
        .clk(clk), .rst_n(rst_n), .en(en), .in1(in1), .in2(in2),
        .out1(p_o1), .out2(p_o2), .out3(p_o3), .out4(p_o4), .valid(p_v)
    );

    decoder_2to4 #(.REGISTERED(1'b0), .ACTIVE_LOW_OUT(1'b0)) u_cmb (
        .clk(clk), .rst_n(rst_n), .en(en), .in1(in1), .in2(in2),
        .out1(c_o1), .out2(c_o2), .out3(c_o3), .out4(c_o4), .valid(c_v)
    );

    initial begin
        forever begin
            #5;
            if (clk_run) clk = ~clk;
        end
    end

    task automatic check(input string nm, input logic [4:0] act, input logic [4:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got out1..4,valid=%b required %b at t=%0t", nm, act, req, $time);
        end
    endtask

    task automatic compare(input string tag, input exp_t e);
        if (e.chk_rp) begin
            check({tag, " reg"}, {r_o1, r_o2, r_o3, r_o4, r_v}, e.exp_r);
            check({tag, " pol"}, {p_o1, p_o2, p_o3, p_o4, p_v}, e.exp_p);
        end
        check({tag, " cmb"}, {c_o1, c_o2, c_o3, c_o4, c_v}, e.exp_c);
    endtask

    // Clocked monitor: one expectation per edge, sampled 1 unit after it.
    initial begin
        exp_t e;
        int   k;
        k = 0;
        forever begin
            @(posedge clk);
            #1;
            if (q_sync.size() > 0) begin
                e = q_sync.pop_front();
                compare($sformatf("edge%0d", k), e);
                k++;
            end
        end
    end

    // Asynchronous monitor: reset and combinational checks with no clock edge.
    initial begin
        exp_t e;
        int   k;
        k = 0;
        forever begin
            @(probe_ev);
            while (q_async.size() > 0) begin
                e = q_async.pop_front();
                compare($sformatf("probe%0d", k), e);
                k++;
            end
        end
    end

    // Drive at the falling edge; hi/lo are out1..out4 for active-high / active-low instances.
    task automatic apply(input logic e_i, input logic a, input logic b,
                         input logic [3:0] hi, input logic [3:0] lo, input logic v);
        exp_t e;
        @(negedge clk);
        en  = e_i;
        in1 = a;
        in2 = b;
        e.chk_rp = 1'b1;
        e.exp_r  = {hi, v};
        e.exp_p  = {lo, v};
        e.exp_c  = {hi, v};
        q_sync.push_back(e);
    endtask

    task automatic probe(input logic rp, input logic [4:0] er, input logic [4:0] ep,
                         input logic [4:0] ec);
        exp_t e;
        e.chk_rp = rp;
        e.exp_r  = er;
        e.exp_p  = ep;
        e.exp_c  = ec;
        q_async.push_back(e);
        -> probe_ev;
        #1;
    endtask

    task automatic cprobe(input logic a, input logic b, input logic [3:0] hi);
        en  = 1'b1;
        in1 = a;
        in2 = b;
        #1;
        probe(1'b0, 5'b0, 5'b0, {hi, 1'b1});
    endtask

    initial begin
        exp_t e;
        en  = 1'b1;
        in1 = 1'b1;
        in2 = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        probe(1'b1, 5'b0000_0, 5'b1111_0, 5'b0000_0);

        // Release with in=11 held: first edge after release decodes it.
        @(negedge clk);
        rst_n = 1'b1;
        e.chk_rp = 1'b1;
        e.exp_r  = 5'b0001_1;
        e.exp_p  = 5'b1110_1;
        e.exp_c  = 5'b0001_1;
        q_sync.push_back(e);

        apply(1'b1, 1'b0, 1'b0, 4'b1000, 4'b0111, 1'b1);
        apply(1'b1, 1'b0, 1'b1, 4'b0100, 4'b1011, 1'b1);
        apply(1'b1, 1'b1, 1'b0, 4'b0010, 4'b1101, 1'b1);
        apply(1'b1, 1'b1, 1'b1, 4'b0001, 4'b1110, 1'b1);

        // Mid-stream reset between edges, released before the next edge.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        probe(1'b1, 5'b0000_0, 5'b1111_0, 5'b0000_0);
        rst_n = 1'b1;
        en  = 1'b1;
        in1 = 1'b0;
        in2 = 1'b1;
        e.exp_r = 5'b0100_1;
        e.exp_p = 5'b1011_1;
        e.exp_c = 5'b0100_1;
        q_sync.push_back(e);

        apply(1'b1, 1'b1, 1'b1, 4'b0001, 4'b1110, 1'b1);
        // en falls together with a code change.
        apply(1'b0, 1'b0, 1'b0, 4'b0000, 4'b1111, 1'b0);
        apply(1'b0, 1'b0, 1'b1, 4'b0000, 4'b1111, 1'b0);
        apply(1'b0, 1'b1, 1'b0, 4'b0000, 4'b1111, 1'b0);
        apply(1'b0, 1'b1, 1'b1, 4'b0000, 4'b1111, 1'b0);
        apply(1'b0, 1'b1, 1'b0, 4'b0000, 4'b1111, 1'b0);
        apply(1'b1, 1'b1, 1'b0, 4'b0010, 4'b1101, 1'b1);
        apply(1'b0, 1'b1, 1'b0, 4'b0000, 4'b1111, 1'b0);

        for (int i = 0; i < 8 && q_sync.size() > 0; i++) @(negedge clk);
        if (q_sync.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", q_sync.size());
        end

        // Stop the clock and step codes on the combinational instance alone.
        @(negedge clk);
        clk_run = 1'b0;
        #2;
        cprobe(1'b0, 1'b0, 4'b1000);
        cprobe(1'b0, 1'b1, 4'b0100);
        cprobe(1'b1, 1'b0, 4'b0010);
        cprobe(1'b1, 1'b1, 4'b0001);

        #2;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/decoder_2to4.md
# decoder_2to4

Two-input, four-output one-hot decoder with optional output registering. The 2-bit code {in1, in2} selects exactly one of out1..out4. In normal use it drives downstream select or enable lines. An enable input forces all outputs inactive, and a valid flag qualifies the outputs.

## Interface
Parameters:
- REGISTERED, default 1: 1 registers outputs on the clock; 0 makes the decode path combinational, still gated by reset.
- ACTIVE_LOW_OUT, default 0: 0 means the selected output is 1 and the others are 0. 1 inverts all four decode outputs. valid is never inverted.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
- en  input  1  decode enable, active-high.
- in1  input  1  code MSB.
- in2  input  1  code LSB.
- out1  output  1  selected when {in1,in2} = 00.
- out2  output  1  selected when {in1,in2} = 01.
- out3  output  1  selected when {in1,in2} = 10.
- out4  output  1  selected when {in1,in2} = 11.
- valid  output  1  high when en was high for the currently presented decode.

## Operation
- The decode is computed on the raw code with polarity applied last:
  - out1 = en & ~in1 & ~in2
  - out2 = en & ~in1 & in2
  - out3 = en & in1 & ~in2
  - out4 = en & in1 & in2
- ACTIVE_LOW_OUT=1 XORs each of out1..out4 with 1.
- Exactly one output is active when en=1. None are active when en=0.
- valid = en, delayed by the same path as the outputs.
- Inactive level means 0 for ACTIVE_LOW_OUT=0 and 1 for ACTIVE_LOW_OUT=1.
- Reset state: out1..out4 at the inactive level, valid=0.
- Unknown inputs are not sanitised. An X or Z on in1, in2 or en may propagate to the outputs, and no X filtering is performed.
- No internal state beyond the output register stage. No FSM.

## Timing
- REGISTERED=1:
  - Latency is 1 cycle. Inputs sampled at a rising clk edge appear on the outputs immediately after that edge.
  - Outputs hold between edges.
  - rst_n low forces the reset state immediately, without waiting for clk, and holds it while low.
  - First capture occurs at the first rising edge after rst_n deasserts. Deassertion is synchronised externally.
- REGISTERED=0:
  - Outputs follow in1, in2 and en combinationally within the same cycle.
  - rst_n low still forces the reset state combinationally.
  - clk is unused in this mode.
- Input changes between edges have no effect in REGISTERED=1 until the next edge.
- Reset asserted mid-operation discards the current decode; no recovery cycle is needed after release.
- Simultaneous en fall and code change at one edge: the outputs go inactive and valid goes 0 at that edge.

## Test plan
- Reset: hold rst_n=0 with en=1 and in=11. Required: out1..out4=0000 and valid=0 before any clock edge. Release, then one edge: out4=1, others 0, valid=1.
- Exhaustive sweep with en=1, REGISTERED=1: apply {in1,in2}=00,01,10,11 on successive edges. One cycle later the outputs (out1..out4) must be:
  - 00 gives 1000
  - 01 gives 0100
  - 10 gives 0010
  - 11 gives 0001
- Enable gating: en=0 with each code gives 0000 and valid=0. Toggle en 0→1→0 with in=10 held: the outputs go 0000, 0010, 0000 on successive edges.
- Combinational mode, REGISTERED=0: step the codes 00..11 at 1 time-unit intervals with no clock. Outputs match the sweep table within the same step.
- Polarity, ACTIVE_LOW_OUT=1: in=01 with en=1 gives 1011 and valid=1. Reset or en=0 gives 1111.
- Async reset mid-stream: during the sweep, pulse rst_n low between edges. The outputs go inactive immediately, and the next post-release edge resumes correct decode.
